z80_bus_responder: RTL and testbench

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_bus_pkg.sv | 42 ++++
 rtl/z80_ram.sv | 33 +++
 rtl/z80_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_z80_bus_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, bus cycle types,
// the default interrupt vector and the strobe decoder.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_HOLD
    } bus_state_e;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MRD,
        CYC_MWR,
        CYC_IORD,
        CYC_IOWR,
        CYC_INTA
    } cyc_type_e;

    localparam logic [7:0] IM2_VEC_DEFAULT = 8'hFF;

    // Refresh suppresses everything; I/O and INTA are checked before memory
    // so an M1 fetch cannot be mistaken for an acknowledge.
    function automatic cyc_type_e decode_cycle(
        input logic m1_n,
        input logic mreq_n,
        input logic iorq_n,
        input logic rd_n,
        input logic wr_n,
        input logic rfsh_n
    );
        if (!rfsh_n)                 return CYC_NONE;
        else if (!iorq_n && !m1_n)   return CYC_INTA;
        else if (!iorq_n && !rd_n)   return CYC_IORD;
        else if (!iorq_n && !wr_n)   return CYC_IOWR;
        else if (!mreq_n && !rd_n)   return CYC_MRD;
        else if (!mreq_n && !wr_n)   return CYC_MWR;
        else                         return CYC_NONE;
    endfunction

endpackage

// File: rtl/z80_ram.sv
// Single-port synchronous byte RAM with registered read, plus a backdoor
// write port used to preload contents. A bus write to the same address in
// the same clock takes precedence over the backdoor write.
module z80_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data
);

    logic [7:0] mem [2**AW];
    logic [7:0] rdata_q;

    // Backdoor write, bus write and registered read.
    always_ff @(posedge clk) begin
        if (ld_en && !(we && (ld_addr == addr))) begin
            mem[ld_addr] <= ld_data;
        end
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: memory (mirrored), 256 I/O ports and interrupt vector,
// with per-space programmable wait states and a saturating write counter.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         MEM_AW   = 12,
    parameter int         MEM_WAIT = 0,
    parameter int         IO_WAIT  = 1,
    parameter logic [7:0] IM2_VEC  = IM2_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       A,
    input  logic [7:0]        cpu_dout,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    output logic [7:0]        di,
    output logic              wait_n,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [15:0]       wr_cnt
);

    bus_state_e  state_q, state_d;
    cyc_type_e   cyc_q, cyc_d;
    cyc_type_e   cyc_now;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  load_cnt;
    logic [7:0]  di_q, di_d;
    logic        wait_n_q, wait_n_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        bus_idle;
    logic        ram_we;
    logic        io_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  io_q [256];
    logic        unused_addr_hi;

    // Memory is mirrored, so the upper address bits play no part.
    assign unused_addr_hi = ^A[15:MEM_AW];

    function automatic logic [2:0] wait_load(input cyc_type_e c);
        case (c)
            CYC_MRD, CYC_MWR:   return 3'(MEM_WAIT);
            CYC_IORD, CYC_IOWR: return 3'(IO_WAIT);
            CYC_INTA:           return 3'd1;
            default:            return 3'd0;
        endcase
    endfunction

    assign cyc_now  = decode_cycle(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
    assign load_cnt = wait_load(cyc_now);
    assign bus_idle = mreq_n & iorq_n & rd_n & wr_n;

    z80_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .addr    (A[MEM_AW-1:0]),
        .we      (ram_we),
        .wdata   (cpu_dout),
        .rdata   (ram_rdata),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // Next-state, wait request, read data and write strobes.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        di_d     = di_q;
        wait_n_d = 1'b1;
        wr_cnt_d = wr_cnt_q;
        ram_we   = 1'b0;
        io_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc_now != CYC_NONE) begin
                    cyc_d = cyc_now;
                    cnt_d = load_cnt;
                    if (load_cnt == 3'd0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d  = ST_WAIT;
                        wait_n_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_idle) begin
                    state_d = ST_IDLE;
                    cyc_d   = CYC_NONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_ACCESS;
                    end else begin
                        wait_n_d = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus_idle) begin
                    state_d = ST_IDLE;
                    cyc_d   = CYC_NONE;
                end else begin
                    state_d = ST_HOLD;
                    case (cyc_q)
                        CYC_MRD:  di_d = ram_rdata;
                        CYC_IORD: di_d = io_q[A[7:0]];
                        CYC_INTA: di_d = IM2_VEC;
                        CYC_MWR: begin
                            ram_we = 1'b1;
                            if (wr_cnt_q != 16'hFFFF) begin
                                wr_cnt_d = wr_cnt_q + 16'd1;
                            end
                        end
                        CYC_IOWR: io_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_HOLD: begin
                if (bus_idle) begin
                    state_d = ST_IDLE;
                    cyc_d   = CYC_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A cycle interrupted by reset must not leave a write behind.
        if (!reset_n) begin
            ram_we = 1'b0;
            io_we  = 1'b0;
        end
    end

    // State and output registers; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cyc_q    <= CYC_NONE;
            cnt_q    <= 3'd0;
            di_q     <= 8'hFF;
            wait_n_q <= 1'b1;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            di_q     <= di_d;
            wait_n_q <= wait_n_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // I/O port registers, decoded on the low address byte.
    always_ff @(posedge clk) begin
        if (io_we) begin
            io_q[A[7:0]] <= cpu_dout;
        end
    end

    assign di     = di_q;
    assign wait_n = wait_n_q;
    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: two instances (no memory waits with the
// default vector, two memory waits with a distinct vector) share one bus.
// A transaction-level model predicts every output after every clock edge.
module tb_z80_bus_responder;

    localparam int T_NONE = 0;
    localparam int T_MRD  = 1;
    localparam int T_MWR  = 2;
    localparam int T_IORD = 3;
    localparam int T_IOWR = 4;
    localparam int T_INTA = 5;
    localparam int T_RFSH = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  di0, di2;
    logic        wait_n0, wait_n2;
    logic [15:0] wr_cnt0, wr_cnt2;

    int n_vec = 0;
    int n_err = 0;
    int wlow2 = 0;

    // model state, index 0 = no-wait instance, 1 = two-wait instance
    logic [7:0]  mmem [2][4096];
    logic [7:0]  mio  [2][256];
    logic [7:0]  exp_di   [2];
    logic        exp_wait [2];
    logic [15:0] exp_cnt  [2];

    int          cyc_typ = T_NONE;
    int          cyc_i   = 0;
    int          cyc_h   = 0;
    logic [15:0] cyc_a;
    logic [7:0]  cyc_d;

    always #5 clk = ~clk;

    z80_bus_responder #(
        .MEM_AW (12), .MEM_WAIT (0), .IO_WAIT (1), .IM2_VEC (8'hFF)
    ) u_dut0 (
        .clk (clk), .reset_n (reset_n), .A (A), .cpu_dout (cpu_dout),
        .m1_n (m1_n), .mreq_n (mreq_n), .iorq_n (iorq_n), .rd_n (rd_n),
        .wr_n (wr_n), .rfsh_n (rfsh_n), .di (di0), .wait_n (wait_n0),
        .ld_en (ld_en), .ld_addr (ld_addr), .ld_data (ld_data), .wr_cnt (wr_cnt0)
    );

    z80_bus_responder #(
        .MEM_AW (12), .MEM_WAIT (2), .IO_WAIT (1), .IM2_VEC (8'h3C)
    ) u_dut2 (
        .clk (clk), .reset_n (reset_n), .A (A), .cpu_dout (cpu_dout),
        .m1_n (m1_n), .mreq_n (mreq_n), .iorq_n (iorq_n), .rd_n (rd_n),
        .wr_n (wr_n), .rfsh_n (rfsh_n), .di (di2), .wait_n (wait_n2),
        .ld_en (ld_en), .ld_addr (ld_addr), .ld_data (ld_data), .wr_cnt (wr_cnt2)
    );

    function automatic int wait_of(input int k, input int typ);
        case (typ)
            T_MRD, T_MWR:   return (k == 0) ? 0 : 2;
            T_IORD, T_IOWR: return 1;
            T_INTA:         return 1;
            default:        return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A bus cycle with wait count w, strobes sampled low at edges 0..h-1:
    // wait_n is low after edges 0..w-1 while strobes stay low, and the
    // access happens at edge w+1 only if the strobes are still low there.
    task automatic model_edge();
        int   w;
        logic acc;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                exp_di[k]   = 8'hFF;
                exp_wait[k] = 1'b1;
                exp_cnt[k]  = 16'd0;
                if (ld_en) mmem[k][ld_addr] = ld_data;
            end
            cyc_typ = T_NONE;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            acc = 1'b0;
            if (cyc_typ != T_NONE && cyc_typ != T_RFSH) begin
                w           = wait_of(k, cyc_typ);
                exp_wait[k] = !(cyc_i < w && cyc_i < cyc_h);
                acc         = (cyc_i == w + 1) && (cyc_h > w + 1);
            end else begin
                exp_wait[k] = 1'b1;
            end
            if (acc) begin
                case (cyc_typ)
                    T_MRD:   exp_di[k] = mmem[k][cyc_a[11:0]];
                    T_IORD:  exp_di[k] = mio[k][cyc_a[7:0]];
                    T_INTA:  exp_di[k] = (k == 0) ? 8'hFF : 8'h3C;
                    default: ;
                endcase
            end
            if (ld_en) mmem[k][ld_addr] = ld_data;
            if (acc && cyc_typ == T_MWR) begin
                mmem[k][cyc_a[11:0]] = cyc_d;
                if (exp_cnt[k] != 16'hFFFF) exp_cnt[k] = exp_cnt[k] + 16'd1;
            end
            if (acc && cyc_typ == T_IOWR) mio[k][cyc_a[7:0]] = cyc_d;
        end
        if (cyc_typ != T_NONE) cyc_i++;
    endtask

    task automatic compare_all();
        check("di0",     16'(di0),     16'(exp_di[0]));
        check("wait_n0", 16'(wait_n0), 16'(exp_wait[0]));
        check("wr_cnt0", wr_cnt0,      exp_cnt[0]);
        check("di2",     16'(di2),     16'(exp_di[1]));
        check("wait_n2", 16'(wait_n2), 16'(exp_wait[1]));
        check("wr_cnt2", wr_cnt2,      exp_cnt[1]);
        if (wait_n2 === 1'b0) wlow2++;
    endtask

    // One clock: edge, model update, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic release_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic drive_bus(input int typ, input logic m1);
        release_bus();
        case (typ)
            T_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = m1; end
            T_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
            T_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
            T_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
            T_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
            T_RFSH: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic run_cycle(input int typ, input logic [15:0] a, input logic [7:0] d,
                             input int h, input logic m1, input int ld_edge,
                             input logic [11:0] la, input logic [7:0] ldv);
        cyc_typ = typ; cyc_a = a; cyc_d = d; cyc_h = h; cyc_i = 0;
        A = a; cpu_dout = d;
        drive_bus(typ, m1);
        for (int i = 0; i < h + 2; i++) begin
            if (i == h) release_bus();
            ld_en = (i == ld_edge); ld_addr = la; ld_data = ldv;
            tick();
            ld_en = 1'b0;
        end
        cyc_typ = T_NONE;
        $display("cycle typ=%0d A=%h d=%h hold=%0d di0=%h di2=%h cnt0=%0d cnt2=%0d",
                 typ, a, d, h, di0, di2, wr_cnt0, wr_cnt2);
    endtask

    task automatic preload(input logic [11:0] la, input logic [7:0] ldv);
        ld_en = 1'b1; ld_addr = la; ld_data = ldv;
        tick();
        ld_en = 1'b0;
        $display("preload mem[%h]=%h", la, ldv);
    endtask

    int w0;

    initial begin
        reset_n = 1'b0; A = 16'h0000; cpu_dout = 8'h00;
        ld_en = 1'b0; ld_addr = 12'h000; ld_data = 8'h00;
        release_bus();
        @(negedge clk);
        tick();
        tick();
        check("rst_di0", 16'(di0), 16'h00FF);
        check("rst_wait_n2", 16'(wait_n2), 16'h0001);
        check("rst_wr_cnt2", wr_cnt2, 16'h0000);
        reset_n = 1'b1;
        tick();

        // zero-wait fetch from preloaded location
        preload(12'h000, 8'hC8);
        run_cycle(T_MRD, 16'h0000, 8'h00, 4, 1'b0, -1, 12'h0, 8'h0);
        check("lit_mrd_di0", 16'(di0), 16'h00C8);

        // write then read through the mirror, two wait clocks each
        w0 = wlow2;
        run_cycle(T_MWR, 16'h13F7, 8'hE9, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_mwr_wlow2", 16'(wlow2 - w0), 16'd2);
        check("lit_mwr_cnt2", wr_cnt2, 16'd1);
        w0 = wlow2;
        run_cycle(T_MRD, 16'h03F7, 8'h00, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_mrd_wlow2", 16'(wlow2 - w0), 16'd2);
        check("lit_mirror_di2", 16'(di2), 16'h00E9);

        // I/O decoded on the low byte only
        run_cycle(T_IOWR, 16'h0042, 8'h5A, 3, 1'b1, -1, 12'h0, 8'h0);
        run_cycle(T_IORD, 16'hFF42, 8'h00, 3, 1'b1, -1, 12'h0, 8'h0);
        check("lit_io_di0", 16'(di0), 16'h005A);

        // interrupt acknowledge and refresh
        run_cycle(T_INTA, 16'h0000, 8'h00, 3, 1'b0, -1, 12'h0, 8'h0);
        check("lit_inta_di2", 16'(di2), 16'h003C);
        check("lit_inta_di0", 16'(di0), 16'h00FF);
        run_cycle(T_RFSH, 16'h0005, 8'h77, 3, 1'b1, -1, 12'h0, 8'h0);

        // long strobes still commit a single write
        run_cycle(T_MWR, 16'h0100, 8'hA1, 6, 1'b1, -1, 12'h0, 8'h0);
        check("lit_long_cnt0", wr_cnt0, 16'd2);

        // backdoor write racing a bus write to the same address
        run_cycle(T_MWR, 16'h0200, 8'hB2, 5, 1'b1, 3, 12'h200, 8'h4D);
        run_cycle(T_MRD, 16'h0200, 8'h00, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_ld_di0", 16'(di0), 16'h004D);
        check("lit_ld_di2", 16'(di2), 16'h00B2);

        // strobes released early: aborted in ACCESS (0 waits) / WAIT (2 waits)
        preload(12'h300, 8'h5E);
        run_cycle(T_MWR, 16'h0300, 8'hC3, 1, 1'b1, -1, 12'h0, 8'h0);
        run_cycle(T_MRD, 16'h0300, 8'h00, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_abort_di2", 16'(di2), 16'h005E);

        // released at the ACCESS edge of the two-wait instance only
        preload(12'h301, 8'h6F);
        run_cycle(T_MWR, 16'h0301, 8'hC4, 3, 1'b1, -1, 12'h0, 8'h0);
        run_cycle(T_MRD, 16'h0301, 8'h00, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_abacc_di0", 16'(di0), 16'h00C4);
        check("lit_abacc_di2", 16'(di2), 16'h006F);

        // reset during WAIT of a write
        preload(12'h302, 8'h71);
        cyc_typ = T_MWR; cyc_a = 16'h0302; cyc_d = 8'hD5; cyc_h = 99; cyc_i = 0;
        A = 16'h0302; cpu_dout = 8'hD5;
        drive_bus(T_MWR, 1'b1);
        tick();
        check("lit_rst_inwait", 16'(wait_n2), 16'h0000);
        reset_n = 1'b0;
        tick();
        check("lit_rst_wait_n2", 16'(wait_n2), 16'h0001);
        check("lit_rst_di2", 16'(di2), 16'h00FF);
        check("lit_rst_cnt2", wr_cnt2, 16'h0000);
        release_bus();
        reset_n = 1'b1;
        cyc_typ = T_NONE;
        tick();
        $display("reset during write: di2=%h cnt2=%0d", di2, wr_cnt2);
        run_cycle(T_MRD, 16'h0302, 8'h00, 4, 1'b1, -1, 12'h0, 8'h0);
        check("lit_rst_nowrite", 16'(di2), 16'h0071);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
